led_s2p: RTL and testbench
==========================

// Module: led_s2p
// PURPOSE
//  Serial-to-parallel receiver for the LED shift-chain protocol (sclk/sout/sclrn/EN).
//  Recovers DATA_BITS-wide words from a serial LED stream, e.g. the GPIO LED port
//  looped back for self-test, or a second board downstream of the chain.
//  Inputs are asynchronous to clk: synchronised, edge-detected, shifted and
//  latched; each latched word is validated against the frame length.
// PARAMETERS
//  DATA_BITS        16  word width = number of sclk edges per frame
//  DATA_COUNT_BITS  4   log2(DATA_BITS); bit counter is DATA_COUNT_BITS+1 wide
//  DIR              0   0: first received bit ends at MSB; 1: first bit ends at LSB
// PORTS
//  clk        in   1          system clock; all registers on posedge clk
//  rst        in   1          asynchronous, active-high reset
//  sclk       in   1          serial clock; data sampled on its rising edge
//  sin        in   1          serial data
//  sclrn      in   1          active-low chain clear
//  pen        in   1          latch strobe; rising edge ends the frame
//  PData      out  DATA_BITS  last valid word
//  valid      out  1          1-cycle pulse when PData updates
//  frame_err  out  1          1-cycle pulse on a bad frame
//  bit_cnt    out  DATA_COUNT_BITS+1  bits received in the current frame
// BEHAVIOUR
//  - Reset: PData=0, valid=0, frame_err=0, bit_cnt=0, shift reg=0, state IDLE.
//    Synchroniser flops reset to: sclk 0, sin 0, sclrn 1, pen 0.
//  - sclk, sin, sclrn and pen each pass through a 2-flop synchroniser plus one
//    history flop. Edge = sync & ~hist. Inputs must hold each level >=3 clk periods.
//  - sclk rising edge: shift in synced sin (DIR=0: shift left, sin->LSB;
//    DIR=1: shift right, sin->MSB). bit_cnt increments and saturates at DATA_BITS+1.
//  - FSM, evaluated each clk (priority: sclrn > pen edge > sclk edge):
//    IDLE  (cnt=0)            sclk edge -> SHIFT (or FULL when DATA_BITS=1)
//    SHIFT (0<cnt<DATA_BITS)  sclk edge at cnt=DATA_BITS-1 -> FULL
//    FULL  (cnt=DATA_BITS)    sclk edge -> OVER
//    OVER  (cnt>DATA_BITS)    stays until pen edge or clear
//  - pen edge in FULL: PData <= shift reg; valid=1 for 1 cycle; clear shift/cnt; -> IDLE.
//  - pen edge in IDLE/SHIFT/OVER: frame_err=1 for 1 cycle; PData held;
//    clear shift/cnt; -> IDLE.
//  - Same-cycle pen and sclk edges: the sclk edge is dropped and the pen edge is
//    handled as above. The bench can only produce this with a deliberate violation.
//  - Synced sclrn low: shift reg and cnt cleared, -> IDLE. sclk and pen edges are
//    ignored while sclrn is low. PData is untouched. No valid or frame_err pulse.
//  - Latency: pen rising at the pin -> PData/valid on the 3rd posedge clk.
//  - valid and frame_err are mutually exclusive; never asserted in the same cycle.
//  - rst asserted mid-frame: immediate return to reset values; the partial frame is lost.
// CONFIGURATION
//  LED_S2P_INVERT_EN defined: PData <= ~shift reg, undoing the inverted polarity of
//    the LED chain, so a transmitted LED value is recovered directly.
//  Undefined: PData <= shift reg (raw line polarity).
//  Reset value of PData is 0 in both cases. No other behaviour changes.
// TESTING
//  1. 16 bits of 0xA55A MSB-first (DIR=0), then pen -> PData=0xA55A; valid 1 cycle;
//     bit_cnt back to 0.
//  2. LED=0x002A transmitted inverted (line word 0xFFD5), LED_S2P_INVERT_EN defined
//     -> PData=0x002A. Same stimulus, macro undefined -> PData=0xFFD5.
//  3. After test 1: 15 bits then pen -> frame_err pulse, PData stays 0xA55A.
//     Then 17 bits then pen -> frame_err pulse, PData stays 0xA55A.
//  4. 8 bits, sclrn low 4 clk, then 16 bits of 0x1234, then pen -> PData=0x1234 and
//     valid. No frame_err at any point.
//  5. rst pulse after 10 bits -> all outputs 0 at once. A following 16-bit frame of
//     0x0F0F -> PData=0x0F0F.
//  6. DIR=1, 16 bits of 0x8001 sent LSB-first, then pen -> PData=0x8001. Back-to-back
//     frames at minimum sclk period -> one valid pulse per frame.

Source files
------------

// File: rtl/led_s2p.sv
// -----------------------------------------------------------------------------
// led_s2p : serial-to-parallel receiver for the LED shift-chain protocol
//
// Recovers DATA_BITS-wide words from an LED serial stream (sclk/sin/sclrn/pen).
// All serial inputs are asynchronous to clk. Each one is passed through a
// two-flop synchroniser and one history flop, and a rising edge is detected.
// Bits are shifted in on sclk rising edges. A pen rising edge ends the frame:
// the word is latched only when exactly DATA_BITS bits were received.
// Otherwise a frame error pulse is raised.
//
// Parameters
//   DATA_BITS        word width, which is also the number of sclk edges per frame
//   DATA_COUNT_BITS  log2(DATA_BITS); bit_cnt is DATA_COUNT_BITS+1 wide
//   DIR              0: first received bit ends at the MSB
//                    1: first received bit ends at the LSB
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   sclk       in   serial clock, sampled on its rising edge
//   sin        in   serial data
//   sclrn      in   active-low chain clear
//   pen        in   latch strobe, rising edge ends the frame
//   PData      out  last valid word
//   valid      out  one-cycle pulse when PData updates
//   frame_err  out  one-cycle pulse on a frame of the wrong length
//   bit_cnt    out  bits received in the current frame (saturates at DATA_BITS+1)
//
// Handshake: valid and frame_err are single-cycle, mutually exclusive pulses.
// PData is stable from the cycle valid is high until the next valid pulse.
// There is no backpressure.
//
// Configuration macro
//   LED_S2P_INVERT_EN : when defined, PData latches the inverted shift register,
//   undoing the inverted polarity of the LED chain. Reset value is 0 either way.
// -----------------------------------------------------------------------------
module led_s2p #(
   parameter int DATA_BITS       = 16,
   parameter int DATA_COUNT_BITS = 4,
   parameter bit DIR             = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sclk,
   input  logic                       sin,
   input  logic                       sclrn,
   input  logic                       pen,
   output logic [DATA_BITS-1:0]       PData,
   output logic                       valid,
   output logic                       frame_err,
   output logic [DATA_COUNT_BITS:0]   bit_cnt
);

   localparam int CW = DATA_COUNT_BITS + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_BITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] SAT_CNT  = CW'(DATA_BITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2,
      OVER  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronisers: meta flop, sync flop, history flop per input
   // ---------------------------------------------------------------------------
   logic sclk_m, sclk_s, sclk_h;
   logic sin_m, sin_s;
   logic sclrn_m, sclrn_s;
   logic pen_m, pen_s, pen_h;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_m  <= 1'b0;
         sclk_s  <= 1'b0;
         sclk_h  <= 1'b0;
         sin_m   <= 1'b0;
         sin_s   <= 1'b0;
         sclrn_m <= 1'b1;
         sclrn_s <= 1'b1;
         pen_m   <= 1'b0;
         pen_s   <= 1'b0;
         pen_h   <= 1'b0;
      end else begin
         sclk_m  <= sclk;
         sclk_s  <= sclk_m;
         sclk_h  <= sclk_s;
         sin_m   <= sin;
         sin_s   <= sin_m;
         sclrn_m <= sclrn;
         sclrn_s <= sclrn_m;
         pen_m   <= pen;
         pen_s   <= pen_m;
         pen_h   <= pen_s;
      end
   end

   logic sclk_rise;
   logic pen_rise;

   assign sclk_rise = sclk_s & ~sclk_h;
   assign pen_rise  = pen_s & ~pen_h;

   // ---------------------------------------------------------------------------
   // Datapath and FSM registers
   // ---------------------------------------------------------------------------
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   pdata_q, pdata_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         pdata_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pdata_q <= pdata_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Shift register contents after one more bit. The loops avoid zero-width
   // slices when DATA_BITS is 1.
   logic [DATA_BITS-1:0] shifted;

   always_comb begin
      shifted = shift_q;
      if (DIR == 1'b0) begin
         shifted[0] = sin_s;
         for (int i = 1; i < DATA_BITS; i++) begin
            shifted[i] = shift_q[i-1];
         end
      end else begin
         shifted[DATA_BITS-1] = sin_s;
         for (int i = 0; i < DATA_BITS - 1; i++) begin
            shifted[i] = shift_q[i+1];
         end
      end
   end

   // Word presented to PData on a good frame
   logic [DATA_BITS-1:0] latch_word;

`ifdef LED_S2P_INVERT_EN
   assign latch_word = ~shift_q;
`else
   assign latch_word = shift_q;
`endif

   // ---------------------------------------------------------------------------
   // Next state. Priority is chain clear, then pen edge, then sclk edge.
   // An sclk edge in the same cycle as a pen edge is dropped.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      pdata_d = pdata_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      if (!sclrn_s) begin
         state_d = IDLE;
         cnt_d   = '0;
         shift_d = '0;
      end else if (pen_rise) begin
         if (state_q == FULL) begin
            pdata_d = latch_word;
            valid_d = 1'b1;
         end else begin
            ferr_d  = 1'b1;
         end
         state_d = IDLE;
         cnt_d   = '0;
         shift_d = '0;
      end else if (sclk_rise) begin
         shift_d = shifted;
         if (cnt_q != SAT_CNT) begin
            cnt_d = cnt_q + CW'(1);
         end
         case (state_q)
            IDLE:    state_d = (DATA_BITS == 1) ? FULL : SHIFT;
            SHIFT:   state_d = (cnt_q == LAST_CNT) ? FULL : SHIFT;
            FULL:    state_d = OVER;
            default: state_d = OVER;
         endcase
      end
   end

   // FULL is also the count-equals-width condition; this keeps the count and
   // the state consistent by construction.
   logic unused_full_cnt;
   assign unused_full_cnt = (cnt_q == FULL_CNT);

   assign PData     = pdata_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_led_s2p.sv
// -----------------------------------------------------------------------------
// tb_led_s2p : self-checking bench for led_s2p
//
// Two instances share the serial inputs: one with DIR=0 and one with DIR=1.
// The reference model keeps the list of bits received in the current frame.
// On pen it forms the expected word for each direction and pushes the expected
// result into that instance's scoreboard queue. A monitor per instance pops
// the queue whenever valid or frame_err pulses.
// -----------------------------------------------------------------------------
module tb_led_s2p;

   localparam int W = 16;

`ifdef LED_S2P_INVERT_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst;
   logic sclk, sin, sclrn, pen;

   always #5 clk = ~clk;

   logic [W-1:0] pdata0, pdata1;
   logic         valid0, valid1, ferr0, ferr1;
   logic [4:0]   cnt0, cnt1;

   led_s2p #(.DATA_BITS(W), .DATA_COUNT_BITS(4), .DIR(1'b0)) dut0 (
      .clk(clk), .rst(rst), .sclk(sclk), .sin(sin), .sclrn(sclrn), .pen(pen),
      .PData(pdata0), .valid(valid0), .frame_err(ferr0), .bit_cnt(cnt0)
   );

   led_s2p #(.DATA_BITS(W), .DATA_COUNT_BITS(4), .DIR(1'b1)) dut1 (
      .clk(clk), .rst(rst), .sclk(sclk), .sin(sin), .sclrn(sclrn), .pen(pen),
      .PData(pdata1), .valid(valid1), .frame_err(ferr1), .bit_cnt(cnt1)
   );

   // ---------------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   bit           err_q0[$];
   bit           err_q1[$];

   bit           frame_bits[$];
   logic [W-1:0] last0 = '0;
   logic [W-1:0] last1 = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitors
   always @(negedge clk) begin
      if (rst === 1'b0 && (valid0 || ferr0)) begin
         check("dut0 valid/frame_err exclusive", {31'd0, valid0 & ferr0}, 32'd0);
         if (err_q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut0 unexpected pulse: valid=%0b frame_err=%0b", valid0, ferr0);
         end else begin
            bit           e;
            logic [W-1:0] w;
            e = err_q0.pop_front();
            w = exp_q0.pop_front();
            check("dut0 frame_err", {31'd0, ferr0}, {31'd0, e});
            check("dut0 PData", {16'd0, pdata0}, {16'd0, w});
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0 && (valid1 || ferr1)) begin
         check("dut1 valid/frame_err exclusive", {31'd0, valid1 & ferr1}, 32'd0);
         if (err_q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1 unexpected pulse: valid=%0b frame_err=%0b", valid1, ferr1);
         end else begin
            bit           e;
            logic [W-1:0] w;
            e = err_q1.pop_front();
            w = exp_q1.pop_front();
            check("dut1 frame_err", {31'd0, ferr1}, {31'd0, e});
            check("dut1 PData", {16'd0, pdata1}, {16'd0, w});
         end
      end
   end

   // ---------------------------------------------------------------- model
   function automatic int exp_cnt();
      return (frame_bits.size() > W) ? W + 1 : frame_bits.size();
   endfunction

   function automatic void model_pen();
      logic [W-1:0] w0, w1;
      if (frame_bits.size() == W) begin
         for (int i = 0; i < W; i++) begin
            w0[W-1-i] = frame_bits[i];
            w1[i]     = frame_bits[i];
         end
         if (INV) begin
            w0 = ~w0;
            w1 = ~w1;
         end
         last0 = w0;
         last1 = w1;
         exp_q0.push_back(w0); err_q0.push_back(1'b0);
         exp_q1.push_back(w1); err_q1.push_back(1'b0);
      end else begin
         exp_q0.push_back(last0); err_q0.push_back(1'b1);
         exp_q1.push_back(last1); err_q1.push_back(1'b1);
      end
      frame_bits.delete();
   endfunction

   // ---------------------------------------------------------------- drivers
   task automatic send_bit(input bit b, input int hold);
      sin = b;
      repeat (hold) @(negedge clk);
      sclk = 1'b1;
      repeat (hold) @(negedge clk);
      sclk = 1'b0;
      frame_bits.push_back(b);
      check("dut0 bit_cnt", {27'd0, cnt0}, exp_cnt());
      check("dut1 bit_cnt", {27'd0, cnt1}, exp_cnt());
   endtask

   // Sends len bits of word. Bits beyond the word width are random filler.
   task automatic send_word(input logic [W-1:0] word, input int len,
                            input bit lsb_first, input int hold);
      for (int i = 0; i < len; i++) begin
         bit b;
         if (i < W) b = lsb_first ? word[i] : word[W-1-i];
         else       b = 1'($urandom_range(0, 1));
         send_bit(b, hold);
      end
   endtask

   task automatic pen_pulse(input int hold);
      model_pen();
      pen = 1'b1;
      repeat (hold) @(negedge clk);
      pen = 1'b0;
      repeat (hold) @(negedge clk);
      check("dut0 bit_cnt after pen", {27'd0, cnt0}, 32'd0);
      check("dut1 bit_cnt after pen", {27'd0, cnt1}, 32'd0);
   endtask

   task automatic chain_clear();
      sclrn = 1'b0;
      repeat (4) @(negedge clk);
      check("dut0 bit_cnt in clear", {27'd0, cnt0}, 32'd0);
      check("dut1 bit_cnt in clear", {27'd0, cnt1}, 32'd0);
      sclrn = 1'b1;
      frame_bits.delete();
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check("rst PData", {16'd0, pdata0}, 32'd0);
      check("rst valid", {31'd0, valid0 | ferr0}, 32'd0);
      check("rst bit_cnt", {27'd0, cnt0 | cnt1}, 32'd0);
      frame_bits.delete();
      last0 = '0;
      last1 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst   = 1'b1;
      sclk  = 1'b0;
      sin   = 1'b0;
      sclrn = 1'b1;
      pen   = 1'b0;
      @(negedge clk);
      check("reset PData", {16'd0, pdata0}, 32'd0);
      check("reset valid", {31'd0, valid0}, 32'd0);
      check("reset frame_err", {31'd0, ferr0}, 32'd0);
      check("reset bit_cnt", {27'd0, cnt0}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Basic MSB-first word
      send_word(16'hA55A, 16, 1'b0, 4);
      pen_pulse(4);
      check("A55A word", {16'd0, pdata0}, INV ? 32'h5AA5 : 32'hA55A);

      // Short and long frames: frame error, PData held
      send_word(16'h1111, 15, 1'b0, 4);
      pen_pulse(4);
      check("short frame hold", {16'd0, pdata0}, INV ? 32'h5AA5 : 32'hA55A);
      send_word(16'h2222, 17, 1'b0, 4);
      pen_pulse(4);
      check("long frame hold", {16'd0, pdata0}, INV ? 32'h5AA5 : 32'hA55A);

      // Inverted LED word on the line
      send_word(16'hFFD5, 16, 1'b0, 3);
      pen_pulse(3);
      check("LED word", {16'd0, pdata0}, INV ? 32'h002A : 32'hFFD5);

      // Chain clear mid-frame
      send_word(16'hFFFF, 8, 1'b0, 4);
      chain_clear();
      send_word(16'h1234, 16, 1'b0, 4);
      pen_pulse(4);
      check("after clear", {16'd0, pdata0}, INV ? 32'hEDCB : 32'h1234);

      // Reset mid-frame
      send_word(16'hFFFF, 10, 1'b0, 4);
      pulse_reset();
      send_word(16'h0F0F, 16, 1'b0, 4);
      pen_pulse(4);
      check("after reset", {16'd0, pdata0}, INV ? 32'hF0F0 : 32'h0F0F);

      // LSB-first word into the DIR=1 instance, then back-to-back frames
      send_word(16'h8001, 16, 1'b1, 3);
      pen_pulse(3);
      check("DIR1 8001", {16'd0, pdata1}, INV ? 32'h7FFE : 32'h8001);
      for (int f = 0; f < 3; f++) begin
         send_word(16'($urandom), 16, 1'b1, 3);
         pen_pulse(3);
      end

      // Randomised frames
      for (int f = 0; f < 20; f++) begin
         int len;
         int hold;
         len  = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(12, 19));
         hold = $urandom_range(3, 5);
         send_word(16'($urandom), len, 1'($urandom_range(0, 1)), hold);
         if ($urandom_range(0, 9) == 0) begin
            chain_clear();
            send_word(16'($urandom), 16, 1'b0, hold);
         end
         pen_pulse(hold);
      end

      repeat (10) @(negedge clk);
      check("dut0 pending results", exp_q0.size(), 32'd0);
      check("dut1 pending results", exp_q1.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
